serial_borrow_subtractor: RTL
=============================

# serial_borrow_subtractor

Multi-cycle, digit-serial subtractor that computes Number1 − Number2 − Borrow_i over WIDTH/DIGIT clock cycles, LSB digit first, using a ripple-borrow slice. It is the inverse-operation companion to the combinational ripple-carry adder in the Adders library. It targets area-constrained datapaths that can tolerate latency. Operands enter and results leave through valid/ready handshakes, so it drops into the same benches and pipelines as the adder family.

## Interface
- WIDTH, 32: operand and result width in bits.
- DIGIT, 4: bits processed per cycle. WIDTH % DIGIT must be 0; elaboration fails otherwise.
- Clk_i  in  1  rising-edge clock.
- Reset_ni  in  1  reset, asynchronous assert, active-low.
- Valid_i  in  1  operands present.
- Ready_o  out  1  block can accept operands.
- Number1_i  in  WIDTH  minuend.
- Number2_i  in  WIDTH  subtrahend.
- Borrow_i  in  1  borrow-in.
- Valid_o  out  1  result present.
- Ready_i  in  1  consumer accepts result.
- Result_o  out  WIDTH  difference, modulo 2^WIDTH.
- Borrow_o  out  1  borrow-out; 1 iff Number1 < Number2 + Borrow_i (unsigned).
- Overflow_o  out  1  two's-complement signed overflow.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- States:
  - IDLE: Ready_o=1, Valid_o=0.
  - RUN: Ready_o=0, Valid_o=0.
  - DONE: Ready_o=0, Valid_o=1.
- IDLE → RUN on a rising edge with Valid_i=1. That edge captures Number1_i, Number2_i and Borrow_i into internal registers, loads the running borrow with Borrow_i, and clears the step counter.
- RUN, per edge:
  - Digit k = {A[k*DIGIT +: DIGIT], B[k*DIGIT +: DIGIT]} goes through the slice with the running borrow.
  - The difference digit is written to Result_o[k*DIGIT +: DIGIT].
  - The running borrow is updated and the counter increments.
- RUN → DONE on the edge that processes digit N−1. On that edge:
  - Borrow_o takes the final borrow.
  - Overflow_o = (A[WIDTH−1] ≠ B[WIDTH−1]) & (R[WIDTH−1] ≠ A[WIDTH−1]).
- DONE → IDLE on an edge with Ready_i=1. Result_o, Borrow_o and Overflow_o hold their values until the next operation's first digit overwrites them.
- Valid_i is ignored outside IDLE. Input operands need only be stable at the accepting edge.
- Ready_i is ignored outside DONE.
- Reset asserted in any state:
  - State goes to IDLE immediately.
  - Result_o=0, Borrow_o=0, Overflow_o=0, Valid_o=0, Ready_o=1.
  - The counter and operand registers clear.
  - The in-flight operation is discarded.

## Timing
- Reset values: Ready_o=1, Valid_o=0, Result_o=0, Borrow_o=0, Overflow_o=0.
- Latency: Valid_o rises N cycles after the accepting edge (8 cycles at defaults).
- Throughput: at most one operation per N+2 cycles (accept, N steps, handoff). DONE and IDLE do not overlap, so there is no back-to-back acceptance.
- In DONE with Ready_i=0: all outputs stay stable indefinitely.
- Ready_o, Valid_o and all outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- DIGIT=WIDTH is legal: N=1, and Valid_o rises 1 cycle after accept.

## Structure
- Shared header adders_defs.vh holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a counter-width helper macro, ceil log2 of N, minimum 1.
- Sub-module borrow_digit (parameter DIGIT) is a combinational DIGIT-bit ripple-borrow slice:
  - inputs: a, b, borrow in;
  - outputs: difference, borrow out;
  - built from per-bit full subtractors: d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
- The top level contains the FSM, step counter, operand registers and result register.

## Test plan
All scenarios use defaults (WIDTH=32, DIGIT=4).
- 0x0000_0001 − 0x0000_0001, Borrow_i=0 → Result_o=0x0000_0000, Borrow_o=0, Overflow_o=0. Valid_o rises exactly 8 cycles after accept.
- 0x0000_0000 − 0x0000_0001, Borrow_i=0 → Result_o=0xFFFF_FFFF, Borrow_o=1, Overflow_o=0.
- 0x8000_0000 − 0x0000_0001, Borrow_i=0 → Result_o=0x7FFF_FFFF, Borrow_o=0, Overflow_o=1.
- 0x0000_0000 − 0x0000_0000, Borrow_i=1 → Result_o=0xFFFF_FFFF, Borrow_o=1, Overflow_o=0. Then 0xFFFF_FFFF − 0xFFFF_FFFF, Borrow_i=1 → Result_o=0xFFFF_FFFF, Borrow_o=1.
- Backpressure:
  - Ready_i=0 for 5 cycles in DONE → outputs and Valid_o stay constant.
  - Valid_i pulsed with new operands during RUN → ignored; the result matches the first operands.
  - Ready_i=1 → IDLE next cycle, Ready_o=1.
- Reset mid-operation: assert Reset_ni low at step 3 of 0x1234_5678 − 0x0000_0001 → immediately IDLE, all outputs 0, Ready_o=1. A subsequent 0x10 − 0x01 → 0x0000_000F.

Source files
------------

// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// the step-counter width helper.
package serial_borrow_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ceil(log2(n)), never less than one bit so N=1 still gets a counter
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_borrow_subtractor_borrow_digit.sv
// Combinational DIGIT-bit ripple-borrow slice built from per-bit full subtractors.
module borrow_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic [DIGIT:0] chain;

    assign chain[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign diff[i]      = a[i] ^ b[i] ^ chain[i];
        assign chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
    end

    assign bout = chain[DIGIT];

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Digit-serial subtractor: Number1 - Number2 - Borrow_i over WIDTH/DIGIT cycles,
// LSB digit first, with valid/ready handshakes on both sides.
module serial_borrow_subtractor
    import serial_borrow_subtractor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             Clk_i,
    input  logic             Reset_ni,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Borrow_i,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [WIDTH-1:0] Result_o,
    output logic             Borrow_o,
    output logic             Overflow_o
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    if (WIDTH % DIGIT != 0) begin : g_width_check
        $error("serial_borrow_subtractor: WIDTH must be a multiple of DIGIT");
    end

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               borrow_q;
    logic [WIDTH-1:0]   result_q;
    logic               borrow_out_q;
    logic               ovf_q;

    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [DIGIT-1:0]   diff_dig;
    logic               bout_dig;
    logic               last_step;

    // Select the operand digit addressed by the step counter
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_dig = a_q[k*DIGIT +: DIGIT];
                b_dig = b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    borrow_digit #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (a_dig),
        .b    (b_dig),
        .bin  (borrow_q),
        .diff (diff_dig),
        .bout (bout_dig)
    );

    assign last_step = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Valid_i)   state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: if (Ready_i)   state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, digit stepping and result accumulation
    always_ff @(posedge Clk_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            result_q     <= '0;
            borrow_out_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && Valid_i) begin
                a_q      <= Number1_i;
                b_q      <= Number2_i;
                borrow_q <= Borrow_i;
                cnt_q    <= '0;
            end
            if (state_q == ST_RUN) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        result_q[k*DIGIT +: DIGIT] <= diff_dig;
                    end
                end
                borrow_q <= bout_dig;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    // The MSB of the result is the top bit of this final digit
                    borrow_out_q <= bout_dig;
                    ovf_q        <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                    (diff_dig[DIGIT-1] ^ a_q[WIDTH-1]);
                end
            end
        end
    end

    assign Ready_o    = (state_q == ST_IDLE);
    assign Valid_o    = (state_q == ST_DONE);
    assign Result_o   = result_q;
    assign Borrow_o   = borrow_out_q;
    assign Overflow_o = ovf_q;

endmodule
